// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for register-file writeback sharing.
//   WB_ADDR_W / WB_DATA_W : default register address / data widths
//   req_idx_e             : requester index (REQ_ALU=0, REQ_LOAD=1)
//   ZERO_REG              : hard-wired zero register, never written
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_idx_e;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin arbiter with a registered last-grant pointer.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_req[1:0]    : request vector (bit n = requester n)
//   o_grant[1:0]  : one-hot grant (combinational)
//   o_grant_idx   : index of the granted requester (valid when |o_grant)
//   o_last        : most recently granted requester (resets to REQ_LOAD)
module rr_arbiter2
    import wb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant,
    output req_idx_e   o_grant_idx,
    output req_idx_e   o_last
);

    req_idx_e r_last;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = REQ_ALU;
        case (i_req)
            2'b01: begin
                o_grant     = 2'b01;
                o_grant_idx = REQ_ALU;
            end
            2'b10: begin
                o_grant     = 2'b10;
                o_grant_idx = REQ_LOAD;
            end
            2'b11: begin
                // Contention: the requester not served last time wins.
                if (r_last == REQ_LOAD) begin
                    o_grant     = 2'b01;
                    o_grant_idx = REQ_ALU;
                end else begin
                    o_grant     = 2'b10;
                    o_grant_idx = REQ_LOAD;
                end
            end
            default: ;
        endcase
    end

    // Every grant is a completed transfer (ready == grant), so the pointer
    // advances whenever anything is granted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= REQ_LOAD;
        end else if (|o_grant) begin
            r_last <= o_grant_idx;
        end
    end

    assign o_last = r_last;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the ALU
// (requester 0) and the load/multi-cycle unit (requester 1).
//   CLK, RST                  : clock, asynchronous active-high reset
//   Rn_VALID/READY/ADDR/DATA  : requester n write handshake
//   A3, WD3, WE3              : registered register-file write port
//   Q1_ADDR/Q2_ADDR, Q1_HIT/Q2_HIT : read-bypass queries against the in-flight write
//   FWD_DATA                  : bypass value (same as WD3)
//   GRANT_LAST                : index of the most recently granted requester
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned Address_Width = WB_ADDR_W,
    parameter int unsigned Data_Width    = WB_DATA_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     R0_VALID,
    output logic                     R0_READY,
    input  logic [Address_Width-1:0] R0_ADDR,
    input  logic [Data_Width-1:0]    R0_DATA,
    input  logic                     R1_VALID,
    output logic                     R1_READY,
    input  logic [Address_Width-1:0] R1_ADDR,
    input  logic [Data_Width-1:0]    R1_DATA,
    output logic [Address_Width-1:0] A3,
    output logic [Data_Width-1:0]    WD3,
    output logic                     WE3,
    input  logic [Address_Width-1:0] Q1_ADDR,
    input  logic [Address_Width-1:0] Q2_ADDR,
    output logic                     Q1_HIT,
    output logic                     Q2_HIT,
    output logic [Data_Width-1:0]    FWD_DATA,
    output logic                     GRANT_LAST
);

    logic [1:0]               w_grant;
    req_idx_e                 w_grant_idx;
    req_idx_e                 w_last;
    logic                     w_xfer;
    logic [Address_Width-1:0] w_addr;
    logic [Data_Width-1:0]    w_data;

    logic [Address_Width-1:0] r_a3;
    logic [Data_Width-1:0]    r_wd3;
    logic                     r_we3;

    rr_arbiter2 u_arb (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_req       ({R1_VALID, R0_VALID}),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_last      (w_last)
    );

    // READY is suppressed during reset so nobody believes a write was taken.
    assign R0_READY = w_grant[0] & ~RST;
    assign R1_READY = w_grant[1] & ~RST;
    assign w_xfer   = |w_grant;

    assign w_addr = (w_grant_idx == REQ_LOAD) ? R1_ADDR : R0_ADDR;
    assign w_data = (w_grant_idx == REQ_LOAD) ? R1_DATA : R0_DATA;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a3  <= '0;
            r_wd3 <= '0;
            r_we3 <= 1'b0;
        end else if (w_xfer) begin
            r_a3  <= w_addr;
            r_wd3 <= w_data;
            // Zero-register writes are accepted but never reach the file.
            r_we3 <= (w_addr != Address_Width'(ZERO_REG));
        end else begin
            r_we3 <= 1'b0;
        end
    end

    assign A3         = r_a3;
    assign WD3        = r_wd3;
    assign WE3        = r_we3;
    assign FWD_DATA   = r_wd3;
    assign GRANT_LAST = w_last;

    assign Q1_HIT = r_we3 && (Q1_ADDR == r_a3) && (Q1_ADDR != Address_Width'(ZERO_REG));
    assign Q2_HIT = r_we3 && (Q2_ADDR == r_a3) && (Q2_ADDR != Address_Width'(ZERO_REG));

endmodule
